// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources; UART_ARB_GUARD_EN adds GUARD_CYCLES idle clocks per frame.
// Latency valid->ready 1 cycle, ->tx_start 2 cycles; no new grant until tx_done_tick_i (plus guard).
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int GUARD_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_din_o,
    input  logic               tx_done_tick_i,
    output logic               busy_o
);
    localparam int LW = $clog2(N_REQ);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ACCEPT    = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
`ifdef UART_ARB_GUARD_EN
    localparam logic [2:0] ST_GUARD     = 3'd4;
    localparam int         CW           = $clog2(GUARD_CYCLES + 1);
`endif

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be in 2..8");
    end
    if (GUARD_CYCLES < 1) begin : g_bad_guard
        $error("uart_tx_arbiter: GUARD_CYCLES must be >= 1");
    end

    logic [2:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [LW-1:0]    r_win;
    logic [LW-1:0]    r_last;
    logic [7:0]       r_din;

    logic [7:0]       w_bytes [N_REQ];
    logic             w_any;
    logic [LW-1:0]    w_win;
    logic [LW-1:0]    w_cand;
    logic [N_REQ-1:0] w_onehot;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign w_bytes[g] = req_data_i[8*g +: 8];
    end

    // Scan from farthest to nearest so the candidate just after r_last wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = r_last;
        w_cand = r_last;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = LW'((int'(r_last) + i) % N_REQ);
            if (req_valid_i[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_onehot = N_REQ'(1) << w_win;

`ifdef UART_ARB_GUARD_EN
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT_DONE && tx_done_tick_i) begin
            r_cnt <= CW'(GUARD_CYCLES - 1);
        end else if (r_state == ST_GUARD && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_win   <= '0;
            r_last  <= LW'(N_REQ - 1);
            r_din   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_win   <= w_win;
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    // A requester that withdrew valid loses the grant without moving the pointer.
                    if (req_valid_i[r_win]) begin
                        r_din   <= w_bytes[r_win];
                        r_last  <= r_win;
                        r_state <= ST_START;
                    end else begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done_tick_i) begin
                        r_grant <= '0;
`ifdef UART_ARB_GUARD_EN
                        r_state <= ST_GUARD;
`else
                        r_state <= ST_IDLE;
`endif
                    end
                end
`ifdef UART_ARB_GUARD_EN
                ST_GUARD: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_ACCEPT) ? r_grant : '0;
    assign grant_o     = r_grant;
    assign tx_start_o  = (r_state == ST_START);
    assign tx_din_o    = r_din;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized byte queues against a rotation model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int GC = 16;
`ifdef UART_ARB_GUARD_EN
    localparam int EXP_GAP = GC + 1;
    localparam bit GUARD   = 1'b1;
`else
    localparam int EXP_GAP = 1;
    localparam bit GUARD   = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_din;
    logic           tx_done = 1'b0;
    logic           busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_m = N - 1;
    logic [7:0] pbuf [N][16];
    int phead [N];
    int ptail [N];
    int order_q [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .GUARD_CYCLES(GC)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .grant_o        (grant),
        .tx_start_o     (tx_start),
        .tx_din_o       (tx_din),
        .tx_done_tick_i (tx_done),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_winner(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] onehot(input int w);
        return (w < 0) ? 32'd0 : (32'd1 << w);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push(input int k, input logic [7:0] b);
        pbuf[k][ptail[k]] = b;
        ptail[k]++;
    endtask

    task automatic clear_pend();
        for (int k = 0; k < N; k++) begin
            phead[k] = 0;
            ptail[k] = 0;
        end
        order_q.delete();
    endtask

    task automatic drive_pend();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (ptail[k] > phead[k]);
            req_data[8*k +: 8] = req_valid[k] ? pbuf[k][phead[k]] : 8'h00;
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) begin
            if (ptail[k] > phead[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        req_data = '0;
        tx_done = 1'b0;
        #3;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_din", 32'(tx_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        last_m = N - 1;
    endtask

    // Plays the requesters and a serializer with random frame length, checking each grant.
    task automatic run(input int max_cyc, input int inj_k, input logic [7:0] inj_b, input bit chk_gap);
        bit exp_start = 0;
        bit in_frame = 0;
        bit done_now = 0;
        bit finished = 0;
        int dly = 0;
        int n = 0;
        int w;
        int done_cyc = -1;
        logic [7:0] exp_din = 8'h00;
        logic [N-1:0] v_drv;
        drive_pend();
        v_drv = req_valid;
        finished = all_empty();
        while (!finished && n < max_cyc) begin
            step();
            n++;
            if (done_now) begin
                tx_done = 1'b0;
                done_now = 0;
                done_cyc = cyc;
                chk("post_done_grant", 32'(grant), 32'd0);
                chk("post_done_busy", 32'(busy), 32'(GUARD));
            end
            if (req_ready != '0) begin
                w = exp_winner(v_drv, last_m);
                chk("ready_onehot", 32'(req_ready), onehot(w));
                chk("grant_at_ready", 32'(grant), onehot(w));
                chk("start_at_ready", 32'(tx_start), 32'd0);
                if (chk_gap && done_cyc >= 0) chk("regrant_gap", 32'(cyc - done_cyc), 32'(EXP_GAP));
                if (w >= 0) begin
                    order_q.push_back(w);
                    exp_din = pbuf[w][phead[w]];
                    last_m = w;
                end
                exp_start = 1;
            end else if (exp_start) begin
                chk("start_pulse", 32'(tx_start), 32'd1);
                chk("start_din", 32'(tx_din), 32'(exp_din));
                chk("start_busy", 32'(busy), 32'd1);
                chk("start_grant", 32'(grant), onehot(last_m));
                phead[last_m]++;
                exp_start = 0;
                in_frame = 1;
                dly = $urandom_range(1, 6);
                if (inj_k >= 0) begin
                    push(inj_k, inj_b);
                    inj_k = -1;
                end
            end else begin
                chk("no_start", 32'(tx_start), 32'd0);
                if (in_frame) begin
                    chk("hold_din", 32'(tx_din), 32'(exp_din));
                    chk("hold_busy", 32'(busy), 32'd1);
                    dly--;
                    if (dly == 0) begin
                        tx_done = 1'b1;
                        done_now = 1;
                        in_frame = 0;
                    end
                end
            end
            drive_pend();
            v_drv = req_valid;
            finished = all_empty() && !in_frame && !exp_start && !done_now;
        end
        chk("run_complete", 32'(finished), 32'd1);
        if (GUARD) begin
            for (int i = 0; i < GC + 2; i++) step();
        end
        step();
        chk("idle_after_run", 32'(busy), 32'd0);
    endtask

    initial begin
        int exp_c [5];
        int cnt [N];
        exp_c = '{0, 1, 2, 3, 0};
        for (int k = 0; k < N; k++) begin
            phead[k] = 0;
            ptail[k] = 0;
        end
        #1;
        do_reset();

        // single request from requester 2
        clear_pend();
        push(2, 8'hCF);
        run(200, -1, 8'h00, 1'b0);
        chk("single_count", 32'(order_q.size()), 32'd1);
        if (order_q.size() > 0) chk("single_who", 32'(order_q[0]), 32'd2);

        // all four valid after reset
        do_reset();
        clear_pend();
        for (int k = 0; k < N; k++) push(k, 8'(8'hA0 + k));
        push(0, 8'hA4);
        run(300, -1, 8'h00, 1'b0);
        chk("all4_count", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < order_q.size(); i++) chk("all4_order", 32'(order_q[i]), 32'(exp_c[i]));

        // round-robin skip with last served = 1
        clear_pend();
        push(1, 8'h11);
        run(200, -1, 8'h00, 1'b0);
        clear_pend();
        push(0, 8'h55);
        push(3, 8'h66);
        run(300, -1, 8'h00, 1'b0);
        chk("skip_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            chk("skip_first", 32'(order_q[0]), 32'd3);
            chk("skip_second", 32'(order_q[1]), 32'd0);
        end

        // re-grant latency after done with requester 1 waiting
        clear_pend();
        push(2, 8'h3C);
        run(300, 1, 8'hD1, 1'b1);
        chk("gap_count", 32'(order_q.size()), 32'd2);

        // random queues
        clear_pend();
        for (int k = 0; k < N; k++) begin
            int m = $urandom_range(0, 4);
            for (int j = 0; j < m; j++) push(k, 8'($urandom));
        end
        run(2000, -1, 8'h00, 1'b0);

        // all continuously valid: strict rotation
        clear_pend();
        for (int k = 0; k < N; k++) begin
            cnt[k] = 0;
            for (int j = 0; j < 4; j++) push(k, 8'($urandom));
        end
        run(2000, -1, 8'h00, 1'b0);
        foreach (order_q[i]) cnt[order_q[i]]++;
        for (int k = 0; k < N; k++) chk("fair_count", 32'(cnt[k]), 32'd4);

        // valid withdrawn during accept
        clear_pend();
        req_valid = '0;
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'h42;
        step();
        chk("viol_ready", 32'(req_ready), 32'h2);
        req_valid[1] = 1'b0;
        step();
        chk("viol_busy", 32'(busy), 32'd0);
        chk("viol_grant", 32'(grant), 32'd0);
        chk("viol_start", 32'(tx_start), 32'd0);

        // spurious done in IDLE
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_grant", 32'(grant), 32'd0);

        // spurious done in START, then reset during WAIT_DONE
        req_valid = 4'b0100;
        req_data[23:16] = 8'h5A;
        step();
        chk("rb_ready", 32'(req_ready), 32'h4);
        step();
        chk("rb_start", 32'(tx_start), 32'd1);
        chk("rb_din", 32'(tx_din), 32'h5A);
        req_valid = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("spur_start_busy", 32'(busy), 32'd1);
        chk("spur_start_grant", 32'(grant), 32'h4);
        for (int i = 0; i < 3; i++) step();
        chk("wait_hold_busy", 32'(busy), 32'd1);
        chk("wait_hold_din", 32'(tx_din), 32'h5A);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_start", 32'(tx_start), 32'd0);
        chk("arst_din", 32'(tx_din), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        #1;
        rstn = 1'b1;
        last_m = N - 1;
        @(negedge clk);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("late_done_busy", 32'(busy), 32'd0);
        chk("late_done_grant", 32'(grant), 32'd0);

        clear_pend();
        push(0, 8'h77);
        push(3, 8'h88);
        run(300, -1, 8'h00, 1'b0);
        chk("post_rst_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() > 0) chk("post_rst_first", 32'(order_q[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer among `N_REQ` byte-producing requesters. Each requester offers one byte at a time over a valid/ready handshake. The arbiter grants one requester and latches its byte. It then pulses `tx_start_o` to the serializer and holds off further grants until the serializer reports `tx_done_tick_i`. It sits between the system's byte sources (status reporter, command echo, debug dump) and the single UART TX line, on the same 100 MHz clock as the UART.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GUARD_CYCLES`, default 16: idle clocks inserted after each frame. Only used when `UART_ARB_GUARD_EN` is defined. Must be ≥1.
- `clk_i`, input, 1: system clock. One clock domain; all logic is rising-edge.
- `rstn_i`, input, 1: asynchronous, active-low reset.
- `req_valid_i`, input, `N_REQ`: per-requester byte valid.
- `req_data_i`, input, `8*N_REQ`: per-requester byte; requester k uses bits `[8k+7:8k]`.
- `req_ready_o`, output, `N_REQ`: per-requester accept; one-hot or zero.
- `grant_o`, output, `N_REQ`: one-hot owner of the current frame; zero when idle.
- `tx_start_o`, output, 1: one-cycle start pulse to `uart_tx`.
- `tx_din_o`, output, 8: byte to `uart_tx`; stable from `tx_start_o` until done.
- `tx_done_tick_i`, input, 1: one-cycle end-of-frame pulse from `uart_tx`.
- `busy_o`, output, 1: high in any state other than IDLE.

## Operation
- States: IDLE, ACCEPT, START, WAIT_DONE, GUARD (GUARD exists only with the macro).
- **IDLE:**
  - If any `req_valid_i` bit is high, select winner `w`.
  - Search order is `last_q+1, last_q+2, …` modulo `N_REQ`; the first valid bit found wins.
  - Register `grant_o` = one-hot(w), then go to ACCEPT. Otherwise stay in IDLE.
- **ACCEPT:**
  - `req_ready_o[w]=1` for exactly this cycle.
  - Transfer occurs at the closing edge: `tx_din_o <= req_data_i[w]` and `last_q <= w`. Go to START.
  - If `req_valid_i[w]` has dropped, this is a protocol violation. Do not capture, clear `grant_o`, and return to IDLE; `last_q` is unchanged.
- **START:**
  - `tx_start_o=1` for one cycle, then go to WAIT_DONE.
- **WAIT_DONE:**
  - Hold `tx_din_o` and `grant_o`.
  - On `tx_done_tick_i`: clear `grant_o`, then go to GUARD (macro defined) or IDLE (macro not defined).
- **GUARD:**
  - Load a down-counter with `GUARD_CYCLES-1` on entry. Decrement each cycle.
  - At 0, go to IDLE.
- `tx_done_tick_i` in any state other than WAIT_DONE is ignored.
- Requester rules:
  - Once a requester asserts `req_valid_i`, it holds valid and data stable until it sees `req_ready_o`.
  - It may present its next byte the cycle after `req_ready_o`.
- `req_ready_o` and `tx_start_o` are Moore outputs decoded from registered state and `grant_o`. There is no combinational path from the inputs to the outputs.
- Counter width is `$clog2(GUARD_CYCLES+1)`. `last_q` width is `$clog2(N_REQ)`.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready_o`, `grant_o`, `tx_start_o`, `tx_din_o`, `busy_o` all = 0.
  - `last_q = N_REQ-1`, so requester 0 has first priority after reset.
  - Guard counter = 0.
- Latency from an idle arbiter:
  - Valid seen at edge E.
  - `req_ready_o` is high during cycle E+1.
  - `tx_start_o` is high during cycle E+2.
- Re-grant after `tx_done_tick_i` at edge D:
  - Earliest next `req_ready_o` without the macro: cycle D+2.
  - With the macro: cycle D+2+`GUARD_CYCLES`.
- Simultaneous requests are served in strict rotation. With all `N_REQ` continuously valid, each requester gets exactly one frame per `N_REQ` frames.
- Asynchronous reset mid-frame:
  - All outputs return to their reset values immediately and the state goes to IDLE.
  - Any in-flight serializer frame is not aborted by this block; `uart_tx` has its own reset.
  - A late `tx_done_tick_i` after reset is ignored.

## Configuration
- `UART_ARB_GUARD_EN`:
  - Defined: GUARD state and counter are compiled in, and `GUARD_CYCLES` idle clocks are inserted after every `tx_done_tick_i`.
  - Undefined: GUARD state and counter are absent, `GUARD_CYCLES` is ignored, and WAIT_DONE goes directly to IDLE.

## Test plan
- **Single request:** requester 2 holds valid with 0xCF from an idle state.
  - `req_ready_o=4'b0100` for 1 cycle.
  - `tx_start_o` in the next cycle with `tx_din_o=0xCF`.
  - `busy_o` high until the done tick.
- **All four valid after reset** with bytes 0xA0..0xA3:
  - Grants occur in order 0,1,2,3,0.
  - Each `tx_din_o` matches its requester's byte.
  - No second `tx_start_o` before each `tx_done_tick_i`.
- **Round-robin skip:** `last_q=1`, valid on requesters 0 and 3 only.
  - Requester 3 is granted first, then requester 0.
- **Guard (macro defined)**, `GUARD_CYCLES=16`, done tick at edge D with requester 1 valid:
  - Next `req_ready_o` in cycle D+18.
- **Guard (macro undefined)**, same stimulus:
  - Next `req_ready_o` in cycle D+2.
- **Robustness:** spurious `tx_done_tick_i` in IDLE or START, then `rstn_i` pulsed low during WAIT_DONE.
  - Spurious ticks cause no state change.
  - After the reset pulse, all outputs are 0 asynchronously, and requester 0 is granted first afterwards.
